// File: rtl/mem_bridge_pkg.sv
// Shared constants, length codes and FSM encoding for the byte-serial memory bridge.
package mem_bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Codes 10 and 11 both mean a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] code);
    case (code)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_bridge_arb.sv
// Fixed-priority requester selection: the MEM stage beats instruction fetch, grants only in IDLE.
module mem_bridge_arb (
  input  logic idle,
  input  logic if_req,
  input  logic mem_req,
  output logic gnt_if,
  output logic gnt_mem
);

  always_comb begin
    gnt_mem = idle & mem_req;
    gnt_if  = idle & if_req & ~mem_req;
  end

endmodule

// File: rtl/mem_bridge.sv
// Bridges 32-bit IF/MEM requests onto a byte-wide RAM/IO bus, one byte per cycle.
module mem_bridge
  import mem_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          len_q, len_d;
  logic                own_mem_q, own_mem_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rbuf_q, rbuf_d;
  logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
  logic [7:0]          ram_dout_q, ram_dout_d;
  logic                ram_wr_q, ram_wr_d;
  logic                if_done_q, if_done_d;
  logic                mem_done_q, mem_done_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

  logic                gnt_if, gnt_mem;
  logic [2:0]          cnt_nxt, cnt_prv;
  logic [ADDR_W-1:0]   sel_addr;

  mem_bridge_arb u_arb (
    .idle    (state_q == IDLE),
    .if_req  (if_req),
    .mem_req (mem_req),
    .gnt_if  (gnt_if),
    .gnt_mem (gnt_mem)
  );

  assign cnt_nxt  = cnt_q + 3'd1;
  assign cnt_prv  = cnt_q - 3'd1;
  assign sel_addr = gnt_mem ? mem_addr : if_addr;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    own_mem_d   = own_mem_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    if_done_d   = if_done_q;
    mem_done_d  = mem_done_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    // With rdy low every register holds, so the stalled byte is simply re-presented.
    if (rdy) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_mem || gnt_if) begin
            addr_d     = sel_addr;
            len_d      = gnt_mem ? len_bytes(mem_len) : 3'd4;
            own_mem_d  = gnt_mem;
            wdata_d    = mem_wdata;
            cnt_d      = 3'd0;
            rbuf_d     = '0;
            ram_a_d    = sel_addr;
            ram_dout_d = mem_wdata[7:0];
            ram_wr_d   = gnt_mem & mem_we;
            state_d    = (gnt_mem && mem_we) ? WRITE : READ;
          end
        end
        READ: begin
          // RAM returns data one cycle after the address, so byte cnt-1 lands now.
          if (cnt_q != 3'd0) begin
            rbuf_d[{cnt_prv[1:0], 3'b000} +: 8] = ram_din;
          end
          if (cnt_q == len_q) begin
            state_d = DONE;
            if (own_mem_q) begin
              mem_rdata_d = rbuf_d;
              mem_done_d  = 1'b1;
            end else begin
              if_rdata_d = rbuf_d;
              if_done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_nxt;
            if (cnt_nxt < len_q) begin
              ram_a_d = addr_q + {29'd0, cnt_nxt};
            end
          end
        end
        WRITE: begin
          if (cnt_q == len_q - 3'd1) begin
            state_d    = DONE;
            ram_wr_d   = 1'b0;
            mem_done_d = 1'b1;
          end else begin
            cnt_d      = cnt_nxt;
            ram_a_d    = addr_q + {29'd0, cnt_nxt};
            ram_dout_d = wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      own_mem_q   <= 1'b0;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      own_mem_q   <= own_mem_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rbuf_q  <= rbuf_d;
  end

  // Stall gating: a frozen cycle neither writes nor signals completion.
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q & rdy;
  assign if_done   = if_done_q & rdy;
  assign mem_done  = mem_done_q & rdy;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed, cycle-exact bench for mem_bridge against a one-cycle-latency RAM that shares rdy.
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_len = 2'b00;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din = 8'd0;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;

  int n_cmp = 0;
  int n_err = 0;

  mem_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_len   (mem_len),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .ram_a     (ram_a),
    .ram_wr    (ram_wr)
  );

  always #5 clk = ~clk;

  // RAM contents: 0x1000..0x1003 hold 13 12 11 10; 0xFFFFFFFF holds EB, 0x0 holds 13.
  function automatic logic [7:0] pat(input logic [31:0] a);
    return (8'h13 - a[7:0]) ^ a[31:24];
  endfunction

  always @(posedge clk) begin
    if (rdy) ram_din <= pat(ram_a);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    tick(); tick();
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_mem_done", {31'd0, mem_done}, 32'd0);
    chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    tick();

    // IF word read at 0x1000
    if_addr = 32'h0000_1000; if_req = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("if_ram_a", ram_a, 32'h1000 + i);
      chk("if_ram_wr", {31'd0, ram_wr}, 32'd0);
      chk("if_done_early", {31'd0, if_done}, 32'd0);
      tick();
    end
    chk("if_done_t5", {31'd0, if_done}, 32'd0);
    chk("if_ram_a_hold", ram_a, 32'h1003);
    tick();
    chk("if_done_t6", {31'd0, if_done}, 32'd1);
    chk("if_rdata", if_rdata, 32'h1011_1213);
    if_req = 1'b0;
    tick();
    chk("if_done_pulse", {31'd0, if_done}, 32'd0);
    chk("if_rdata_hold", if_rdata, 32'h1011_1213);

    // Simultaneous requests: MEM byte load at 0x20 wins
    if_req = 1'b1; if_addr = 32'h0000_1000;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h20;
    tick();
    chk("arb_ram_a", ram_a, 32'h20);
    tick();
    chk("arb_ram_a_hold", ram_a, 32'h20);
    chk("arb_mem_done_early", {31'd0, mem_done}, 32'd0);
    tick();
    chk("arb_mem_done", {31'd0, mem_done}, 32'd1);
    chk("arb_if_done", {31'd0, if_done}, 32'd0);
    chk("arb_mem_rdata", mem_rdata, 32'h0000_00F3);
    mem_req = 1'b0;
    tick();
    chk("arb_idle_mem_done", {31'd0, mem_done}, 32'd0);
    chk("arb_idle_ram_a", ram_a, 32'h20);
    tick();
    chk("arb_if_start", ram_a, 32'h1000);
    repeat (5) tick();
    chk("arb_if_done", {31'd0, if_done}, 32'd1);
    chk("arb_if_rdata", if_rdata, 32'h1011_1213);
    chk("arb_mem_rdata_hold", mem_rdata, 32'h0000_00F3);
    if_req = 1'b0;
    tick();

    // Word store 0xDEADBEEF at 0x100
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10;
    mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
    tick();
    chk("st_a0", ram_a, 32'h100);  chk("st_d0", {24'd0, ram_dout}, 32'hEF); chk("st_w0", {31'd0, ram_wr}, 32'd1);
    tick();
    chk("st_a1", ram_a, 32'h101);  chk("st_d1", {24'd0, ram_dout}, 32'hBE); chk("st_w1", {31'd0, ram_wr}, 32'd1);
    tick();
    chk("st_a2", ram_a, 32'h102);  chk("st_d2", {24'd0, ram_dout}, 32'hAD); chk("st_w2", {31'd0, ram_wr}, 32'd1);
    tick();
    chk("st_a3", ram_a, 32'h103);  chk("st_d3", {24'd0, ram_dout}, 32'hDE); chk("st_w3", {31'd0, ram_wr}, 32'd1);
    chk("st_done_early", {31'd0, mem_done}, 32'd0);
    tick();
    chk("st_done", {31'd0, mem_done}, 32'd1);
    chk("st_wr_off", {31'd0, ram_wr}, 32'd0);
    mem_req = 1'b0;
    tick();
    chk("st_done_pulse", {31'd0, mem_done}, 32'd0);
    chk("st_rdata_hold", mem_rdata, 32'h0000_00F3);

    // IF read at 0x2040 with rdy low 3 cycles on byte 2; mem_we high must not leak into IF
    mem_we = 1'b1;
    if_addr = 32'h0000_2040; if_req = 1'b1;
    tick();
    chk("stl_a0", ram_a, 32'h2040);
    tick();
    chk("stl_a1", ram_a, 32'h2041);
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stl_frz_a", ram_a, 32'h2042);
      chk("stl_frz_wr", {31'd0, ram_wr}, 32'd0);
      chk("stl_frz_done", {31'd0, if_done}, 32'd0);
      tick();
    end
    rdy = 1'b1;
    chk("stl_reissue_a", ram_a, 32'h2042);
    tick();
    chk("stl_a3", ram_a, 32'h2043);
    chk("stl_if_wr", {31'd0, ram_wr}, 32'd0);
    tick();
    chk("stl_done_early", {31'd0, if_done}, 32'd0);
    tick();
    chk("stl_done", {31'd0, if_done}, 32'd1);
    chk("stl_rdata", if_rdata, 32'hD0D1_D2D3);
    if_req = 1'b0;
    tick();

    // Reset (with rdy low) aborts a word store at its third byte
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b11;
    mem_addr = 32'h300; mem_wdata = 32'h1122_3344;
    tick();
    chk("ab_a0", ram_a, 32'h300); chk("ab_d0", {24'd0, ram_dout}, 32'h44);
    tick();
    chk("ab_a1", ram_a, 32'h301); chk("ab_d1", {24'd0, ram_dout}, 32'h33);
    tick();
    chk("ab_a2", ram_a, 32'h302); chk("ab_w2", {31'd0, ram_wr}, 32'd1);
    rst = 1'b1; rdy = 1'b0; mem_req = 1'b0;
    tick();
    rst = 1'b0; rdy = 1'b1;
    chk("ab_wr", {31'd0, ram_wr}, 32'd0);
    chk("ab_done", {31'd0, mem_done}, 32'd0);
    chk("ab_ram_a", ram_a, 32'd0);
    chk("ab_ram_dout", {24'd0, ram_dout}, 32'd0);
    chk("ab_if_rdata", if_rdata, 32'd0);
    chk("ab_mem_rdata", mem_rdata, 32'd0);
    tick();
    chk("ab_idle_wr", {31'd0, ram_wr}, 32'd0);
    chk("ab_idle_done", {31'd0, mem_done}, 32'd0);

    // Half load at 0xFFFFFFFF wraps to 0x00000000
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b01; mem_addr = 32'hFFFF_FFFF;
    tick();
    chk("hw_a0", ram_a, 32'hFFFF_FFFF);
    tick();
    chk("hw_a1", ram_a, 32'h0000_0000);
    tick();
    chk("hw_done_early", {31'd0, mem_done}, 32'd0);
    tick();
    chk("hw_done", {31'd0, mem_done}, 32'd1);
    chk("hw_rdata", mem_rdata, 32'h0000_13EB);
    chk("hw_upper", {16'd0, mem_rdata[31:16]}, 32'd0);
    mem_req = 1'b0;
    tick();
    chk("hw_done_pulse", {31'd0, mem_done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameters (none beyond shared constants): ADDR_W, 32, address width; DATA_W, 32, requester data width.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock; all state changes on posedge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 rdy  in  1  global ready; low freezes the block.
REQ-006 if_req  in  1  IF fetch request; always a 4-byte read; held until if_done.
REQ-007 if_addr  in  32  IF fetch byte address.
REQ-008 if_done  out  1  one-cycle pulse; if_rdata valid.
REQ-009 if_rdata  out  32  fetched word, little-endian.
REQ-010 mem_req  in  1  MEM-stage request; held until mem_done.
REQ-011 mem_we  in  1  1 = store, 0 = load.
REQ-012 mem_len  in  2  00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes.
REQ-013 mem_addr  in  32  MEM byte address.
REQ-014 mem_wdata  in  32  store data; byte i = bits [8i+7:8i].
REQ-015 mem_done  out  1  one-cycle pulse; mem_rdata valid for loads.
REQ-016 mem_rdata  out  32  load data, zero-extended above len.
REQ-017 ram_din  in  8  RAM/IO byte read bus.
REQ-018 ram_dout  out  8  RAM/IO byte write bus.
REQ-019 ram_a  out  32  byte address bus.
REQ-020 ram_wr  out  1  1 = write strobe, 0 = read.

Function
REQ-021 States SHALL be IDLE, READ, WRITE, DONE; all RAM outputs SHALL be registered.
REQ-022 In IDLE, a request SHALL be accepted on the edge closing cycle T; if mem_req and if_req are both high, MEM SHALL win and IF SHALL wait.
REQ-023 On acceptance, the block SHALL latch the address, the length n (1, 2 or 4; n = 4 for IF), the write data and the owner.
REQ-024 READ: in cycle T+1+i, ram_a SHALL be addr+i and ram_wr SHALL be 0, for i = 0..n-1.
REQ-025 READ: ram_din SHALL be sampled at the end of cycle T+2+i into byte i of the read data.
REQ-026 READ: the owner's done SHALL pulse in cycle T+2+n, so a 4-byte read completes at T+6.
REQ-027 WRITE: in cycle T+1+i, ram_a SHALL be addr+i, ram_dout SHALL be byte i and ram_wr SHALL be 1; mem_done SHALL pulse in cycle T+1+n.
REQ-028 A write requested by IF is impossible by construction; if_req SHALL never generate ram_wr = 1.
REQ-029 rdata SHALL hold its value after done until the next completion by the same owner.
REQ-030 In DONE, requests SHALL be ignored; the next cycle SHALL be IDLE, where arbitration resumes.
REQ-031 Outside WRITE, ram_wr SHALL be 0; idle ram_a SHALL hold its last value.
REQ-032 Address increment SHALL wrap modulo 2^32; addresses with ram_a[17:16] = 11 (IO) SHALL receive no special handling.
REQ-033 rdy low SHALL freeze the state, counter, latched data and ram_a, SHALL force ram_wr to 0, and SHALL not pulse done.
REQ-034 On rdy returning high, the interrupted byte SHALL be reissued.

Reset
REQ-035 While rst is high at a posedge: state = IDLE; if_done = mem_done = ram_wr = 0; ram_a = 0; ram_dout = 0; if_rdata = mem_rdata = 0.
REQ-036 rst SHALL abort any transfer mid-operation without a done pulse.
REQ-037 rst SHALL take priority over rdy.

Structure
REQ-038 MemAddrBus, MemBus, the len codes (LenByte, LenHalf, LenWord) and the state encodings SHALL live in defines.v.
REQ-039 Fixed-priority selection SHALL be a sub-module, mem_bridge_arb (2 requests in, grant out, grant only in IDLE).

Verification
REQ-040 IF read of 0x00001000 with RAM bytes 13 12 11 10 -> ram_a 0x1000..0x1003 on T+1..T+4; if_done at T+6; if_rdata = 0x10111213.
REQ-041 Simultaneous if_req and mem_req (load, len 00, addr 0x20) -> MEM served first and mem_rdata = 0x000000BYTE; IF is accepted the cycle after the mem_done cycle.
REQ-042 Store word 0xDEADBEEF at 0x100 -> (ram_a, ram_dout, ram_wr) = (0x100,EF,1), (0x101,BE,1), (0x102,AD,1), (0x103,DE,1); mem_done at T+5.
REQ-043 rdy low for 3 cycles during byte 2 of an IF read -> ram_wr 0, ram_a frozen, no done; on resume the byte is reissued and the correct word is returned 3 cycles late.
REQ-044 rst asserted at T+3 of a 4-byte store -> next cycle ram_wr = 0, state IDLE, no mem_done.
REQ-045 Half load at 0xFFFFFFFF -> ram_a 0xFFFFFFFF then 0x00000000; upper 16 bits of mem_rdata = 0.
